mac_operand_packer: RTL and testbench

- Producer side of the SIMD MAC operand interface.
- Accepts a narrow valid/ready stream of (a,b) element pairs, ELEMS_PER_BEAT per beat, and packs them into SIMD_WIDTH-lane vectors in a ping-pong double buffer.
- Drives input_valid/a/b of the MAC array for one cycle per completed vector.
- Sits between the operand fetch/SRAM read logic and the MAC datapath.

---
 rtl/mac_pkg.sv | 27 ++
 rtl/mac_operand_packer_bank.sv | 65 ++++++
 rtl/mac_operand_packer.sv | 200 ++++++++++++++++++++
 tb/tb_mac_operand_packer.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mac_pkg.sv
// Shared constants, buffer descriptor type and sizing helpers for the SIMD MAC
// operand packer (mac_operand_packer and its packer_bank sub-module).
package mac_pkg;

    localparam int DEF_A_WIDTH        = 16;
    localparam int DEF_B_WIDTH        = 16;
    localparam int DEF_SIMD_WIDTH     = 36;
    localparam int DEF_ELEMS_PER_BEAT = 4;

    // Stored beat count width; bounds BEATS to 255 per vector.
    localparam int BEAT_CNT_W = 8;

    typedef struct packed {
        logic                  full;
        logic [BEAT_CNT_W-1:0] beats;
        logic                  last;
    } buf_desc_t;

    function automatic int calc_beats(input int simd_width, input int elems_per_beat);
        return simd_width / elems_per_beat;
    endfunction

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mac_operand_packer_bank.sv
// packer_bank: one vector buffer of the ping-pong pair. Beat-indexed lane write,
// combinational read with lanes beyond the stored beat count forced to zero.
module packer_bank
    import mac_pkg::*;
#(
    parameter int A_WIDTH        = DEF_A_WIDTH,
    parameter int B_WIDTH        = DEF_B_WIDTH,
    parameter int SIMD_WIDTH     = DEF_SIMD_WIDTH,
    parameter int ELEMS_PER_BEAT = DEF_ELEMS_PER_BEAT,
    parameter int IDX_W          = idx_width(calc_beats(SIMD_WIDTH, ELEMS_PER_BEAT))
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         wr_en_i,
    input  logic [IDX_W-1:0]             wr_beat_i,
    input  logic signed [A_WIDTH-1:0]    wr_a_i [ELEMS_PER_BEAT],
    input  logic signed [B_WIDTH-1:0]    wr_b_i [ELEMS_PER_BEAT],
    input  logic [BEAT_CNT_W-1:0]        rd_beats_i,
    output logic signed [A_WIDTH-1:0]    rd_a_o [SIMD_WIDTH],
    output logic signed [B_WIDTH-1:0]    rd_b_o [SIMD_WIDTH]
);

    logic signed [A_WIDTH-1:0] a_q [SIMD_WIDTH];
    logic signed [A_WIDTH-1:0] a_d [SIMD_WIDTH];
    logic signed [B_WIDTH-1:0] b_q [SIMD_WIDTH];
    logic signed [B_WIDTH-1:0] b_d [SIMD_WIDTH];

    always_comb begin
        for (int i = 0; i < SIMD_WIDTH; i++) begin
            a_d[i] = a_q[i];
            b_d[i] = b_q[i];
            if (wr_en_i && (i / ELEMS_PER_BEAT == int'(wr_beat_i))) begin
                a_d[i] = wr_a_i[i % ELEMS_PER_BEAT];
                b_d[i] = wr_b_i[i % ELEMS_PER_BEAT];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SIMD_WIDTH; i++) begin
                a_q[i] <= '0;
                b_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < SIMD_WIDTH; i++) begin
                a_q[i] <= a_d[i];
                b_q[i] <= b_d[i];
            end
        end
    end

    // Padded lanes read as zero so a short vector contributes nothing extra to the MAC sum.
    always_comb begin
        for (int i = 0; i < SIMD_WIDTH; i++) begin
            rd_a_o[i] = '0;
            rd_b_o[i] = '0;
            if (i / ELEMS_PER_BEAT < int'(rd_beats_i)) begin
                rd_a_o[i] = a_q[i];
                rd_b_o[i] = b_q[i];
            end
        end
    end

endmodule

// File: rtl/mac_operand_packer.sv
// Packs a narrow (a,b) beat stream into SIMD_WIDTH-lane vectors via a ping-pong
// buffer pair and issues them to the MAC array. Optional MAC_OPERAND_PACKER_STATS_EN adds counters.
module mac_operand_packer
    import mac_pkg::*;
#(
    parameter int A_WIDTH        = DEF_A_WIDTH,
    parameter int B_WIDTH        = DEF_B_WIDTH,
    parameter int SIMD_WIDTH     = DEF_SIMD_WIDTH,
    parameter int ELEMS_PER_BEAT = DEF_ELEMS_PER_BEAT
) (
    input  logic                         clk,
    input  logic                         arst_in,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic signed [A_WIDTH-1:0]    in_a [ELEMS_PER_BEAT],
    input  logic signed [B_WIDTH-1:0]    in_b [ELEMS_PER_BEAT],
    input  logic                         in_last,
    input  logic                         issue_stall,
    output logic                         input_valid,
    output logic signed [A_WIDTH-1:0]    a [SIMD_WIDTH],
    output logic signed [B_WIDTH-1:0]    b [SIMD_WIDTH],
    output logic                         vec_last
`ifdef MAC_OPERAND_PACKER_STATS_EN
    ,
    output logic [31:0]                  stat_vectors,
    output logic [31:0]                  stat_padded
`endif
);

    localparam int BEATS = calc_beats(SIMD_WIDTH, ELEMS_PER_BEAT);
    localparam int IDX_W = idx_width(BEATS);

    if (SIMD_WIDTH % ELEMS_PER_BEAT != 0) begin : g_width_check
        $error("mac_operand_packer: SIMD_WIDTH must be a multiple of ELEMS_PER_BEAT");
    end
    if (BEATS >= (1 << BEAT_CNT_W)) begin : g_beats_check
        $error("mac_operand_packer: too many beats per vector for the descriptor");
    end

    logic             wr_sel_q, wr_sel_d;
    logic             rd_sel_q, rd_sel_d;
    logic [IDX_W-1:0] beat_cnt_q, beat_cnt_d;
    buf_desc_t        desc_q [2];
    buf_desc_t        desc_d [2];
    logic             input_valid_q, input_valid_d;
    logic             vec_last_q, vec_last_d;
    logic signed [A_WIDTH-1:0] a_q [SIMD_WIDTH];
    logic signed [A_WIDTH-1:0] a_d [SIMD_WIDTH];
    logic signed [B_WIDTH-1:0] b_q [SIMD_WIDTH];
    logic signed [B_WIDTH-1:0] b_d [SIMD_WIDTH];

    logic beat_accept;
    logic buf_close;
    logic vec_issue;

    logic signed [A_WIDTH-1:0] ping_a [SIMD_WIDTH];
    logic signed [B_WIDTH-1:0] ping_b [SIMD_WIDTH];
    logic signed [A_WIDTH-1:0] pong_a [SIMD_WIDTH];
    logic signed [B_WIDTH-1:0] pong_b [SIMD_WIDTH];

    assign in_ready    = !desc_q[wr_sel_q].full && !arst_in;
    assign beat_accept = in_valid && in_ready;
    assign buf_close   = beat_accept && ((beat_cnt_q == IDX_W'(BEATS - 1)) || in_last);
    assign vec_issue   = desc_q[rd_sel_q].full && !issue_stall;

    packer_bank #(
        .A_WIDTH        (A_WIDTH),
        .B_WIDTH        (B_WIDTH),
        .SIMD_WIDTH     (SIMD_WIDTH),
        .ELEMS_PER_BEAT (ELEMS_PER_BEAT),
        .IDX_W          (IDX_W)
    ) u_ping (
        .clk        (clk),
        .rst        (arst_in),
        .wr_en_i    (beat_accept && !wr_sel_q),
        .wr_beat_i  (beat_cnt_q),
        .wr_a_i     (in_a),
        .wr_b_i     (in_b),
        .rd_beats_i (desc_q[0].beats),
        .rd_a_o     (ping_a),
        .rd_b_o     (ping_b)
    );

    packer_bank #(
        .A_WIDTH        (A_WIDTH),
        .B_WIDTH        (B_WIDTH),
        .SIMD_WIDTH     (SIMD_WIDTH),
        .ELEMS_PER_BEAT (ELEMS_PER_BEAT),
        .IDX_W          (IDX_W)
    ) u_pong (
        .clk        (clk),
        .rst        (arst_in),
        .wr_en_i    (beat_accept && wr_sel_q),
        .wr_beat_i  (beat_cnt_q),
        .wr_a_i     (in_a),
        .wr_b_i     (in_b),
        .rd_beats_i (desc_q[1].beats),
        .rd_a_o     (pong_a),
        .rd_b_o     (pong_b)
    );

    // Close and issue never target the same buffer: close needs it empty, issue needs it full.
    always_comb begin
        wr_sel_d      = wr_sel_q;
        rd_sel_d      = rd_sel_q;
        beat_cnt_d    = beat_cnt_q;
        desc_d        = desc_q;
        input_valid_d = 1'b0;
        vec_last_d    = vec_last_q;
        a_d           = a_q;
        b_d           = b_q;

        if (beat_accept) begin
            if (buf_close) begin
                desc_d[wr_sel_q].full  = 1'b1;
                desc_d[wr_sel_q].beats = BEAT_CNT_W'(beat_cnt_q) + 1'b1;
                desc_d[wr_sel_q].last  = in_last;
                beat_cnt_d             = '0;
                wr_sel_d               = !wr_sel_q;
            end else begin
                beat_cnt_d = beat_cnt_q + 1'b1;
            end
        end

        if (vec_issue) begin
            desc_d[rd_sel_q].full = 1'b0;
            rd_sel_d              = !rd_sel_q;
            input_valid_d         = 1'b1;
            vec_last_d            = desc_q[rd_sel_q].last;
            for (int i = 0; i < SIMD_WIDTH; i++) begin
                a_d[i] = rd_sel_q ? pong_a[i] : ping_a[i];
                b_d[i] = rd_sel_q ? pong_b[i] : ping_b[i];
            end
        end
    end

    always_ff @(posedge clk or posedge arst_in) begin
        if (arst_in) begin
            wr_sel_q      <= 1'b0;
            rd_sel_q      <= 1'b0;
            beat_cnt_q    <= '0;
            desc_q[0]     <= '0;
            desc_q[1]     <= '0;
            input_valid_q <= 1'b0;
            vec_last_q    <= 1'b0;
            for (int i = 0; i < SIMD_WIDTH; i++) begin
                a_q[i] <= '0;
                b_q[i] <= '0;
            end
        end else begin
            wr_sel_q      <= wr_sel_d;
            rd_sel_q      <= rd_sel_d;
            beat_cnt_q    <= beat_cnt_d;
            desc_q[0]     <= desc_d[0];
            desc_q[1]     <= desc_d[1];
            input_valid_q <= input_valid_d;
            vec_last_q    <= vec_last_d;
            for (int i = 0; i < SIMD_WIDTH; i++) begin
                a_q[i] <= a_d[i];
                b_q[i] <= b_d[i];
            end
        end
    end

    assign input_valid = input_valid_q;
    assign vec_last    = vec_last_q;
    assign a           = a_q;
    assign b           = b_q;

`ifdef MAC_OPERAND_PACKER_STATS_EN
    logic [31:0] stat_vectors_q, stat_vectors_d;
    logic [31:0] stat_padded_q, stat_padded_d;

    // A vector counts as padded when it closed before filling every beat.
    always_comb begin
        stat_vectors_d = stat_vectors_q;
        stat_padded_d  = stat_padded_q;
        if (vec_issue) begin
            stat_vectors_d = stat_vectors_q + 32'd1;
            if (int'(desc_q[rd_sel_q].beats) < BEATS) begin
                stat_padded_d = stat_padded_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge arst_in) begin
        if (arst_in) begin
            stat_vectors_q <= '0;
            stat_padded_q  <= '0;
        end else begin
            stat_vectors_q <= stat_vectors_d;
            stat_padded_q  <= stat_padded_d;
        end
    end

    assign stat_vectors = stat_vectors_q;
    assign stat_padded  = stat_padded_q;
`endif

endmodule

// File: tb/tb_mac_operand_packer.sv
// Directed bench for mac_operand_packer; define MAC_OPERAND_PACKER_STATS_EN to also
// cover the statistics counters.
module tb_mac_operand_packer;

    localparam int AW    = 16;
    localparam int BW    = 16;
    localparam int SIMD  = 36;
    localparam int EPB   = 4;
    localparam int BEATS = 9;

    logic clk = 1'b0;
    logic arstIn;
    logic inValid;
    logic inReady;
    logic signed [AW-1:0] inA [EPB];
    logic signed [BW-1:0] inB [EPB];
    logic inLast;
    logic issueStall;
    logic inputValid;
    logic signed [AW-1:0] aOut [SIMD];
    logic signed [BW-1:0] bOut [SIMD];
    logic vecLast;
`ifdef MAC_OPERAND_PACKER_STATS_EN
    logic [31:0] statVectors;
    logic [31:0] statPadded;
`endif

    always #5 clk = ~clk;

    mac_operand_packer #(
        .A_WIDTH        (AW),
        .B_WIDTH        (BW),
        .SIMD_WIDTH     (SIMD),
        .ELEMS_PER_BEAT (EPB)
    ) dut (
        .clk         (clk),
        .arst_in     (arstIn),
        .in_valid    (inValid),
        .in_ready    (inReady),
        .in_a        (inA),
        .in_b        (inB),
        .in_last     (inLast),
        .issue_stall (issueStall),
        .input_valid (inputValid),
        .a           (aOut),
        .b           (bOut),
        .vec_last    (vecLast)
`ifdef MAC_OPERAND_PACKER_STATS_EN
        ,
        .stat_vectors (statVectors),
        .stat_padded  (statPadded)
`endif
    );

    typedef struct packed {
        logic [31:0]        cyc;
        logic               last;
        logic [SIMD*AW-1:0] aFlat;
        logic [SIMD*BW-1:0] bFlat;
    } pulse_t;

    pulse_t pulseQ[$];
    int cycleCnt = 0;
    int lastAcceptCyc = 0;
    int checks = 0;
    int errors = 0;
    logic [AW-1:0] expA [SIMD];
    logic [BW-1:0] expB [SIMD];

    // Captures every issued vector half a cycle after the edge that launched it.
    always @(negedge clk) begin
        pulse_t p;
        cycleCnt = cycleCnt + 1;
        if (inputValid === 1'b1) begin
            p.cyc  = 32'(cycleCnt);
            p.last = vecLast;
            for (int i = 0; i < SIMD; i++) begin
                p.aFlat[i*AW +: AW] = aOut[i];
                p.bFlat[i*BW +: BW] = bOut[i];
            end
            pulseQ.push_back(p);
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Offers one beat for one clock; lane j carries aBase+j, every b lane carries bVal.
    task automatic applyStimulus(input int aBase, input int bVal, input bit last, output bit took);
        for (int j = 0; j < EPB; j++) begin
            inA[j] = AW'(aBase + j);
            inB[j] = BW'(bVal);
        end
        inLast  = last;
        inValid = 1'b1;
        took    = inReady;
        @(posedge clk);
        #1;
        if (took) lastAcceptCyc = cycleCnt;
        inValid = 1'b0;
        inLast  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic checkVector(input string name, input int k, input logic expLast);
        pulse_t p;
        if (k >= pulseQ.size()) begin
            checkOutput({name, ".present"}, 32'd0, 32'd1);
            return;
        end
        p = pulseQ[k];
        checkOutput({name, ".vec_last"}, 32'(p.last), 32'(expLast));
        for (int i = 0; i < SIMD; i++) begin
            checkOutput($sformatf("%s.a[%0d]", name, i), 32'(p.aFlat[i*AW +: AW]), 32'(expA[i]));
            checkOutput($sformatf("%s.b[%0d]", name, i), 32'(p.bFlat[i*BW +: BW]), 32'(expB[i]));
        end
    endtask

    task automatic checkResetOutputs(input string name);
        checkOutput({name, ".input_valid"}, 32'(inputValid), 32'd0);
        checkOutput({name, ".vec_last"}, 32'(vecLast), 32'd0);
        checkOutput({name, ".in_ready"}, 32'(inReady), 32'd0);
        checkOutput({name, ".a0"}, 32'(unsigned'(aOut[0])), 32'd0);
        checkOutput({name, ".a35"}, 32'(unsigned'(aOut[SIMD-1])), 32'd0);
        checkOutput({name, ".b0"}, 32'(unsigned'(bOut[0])), 32'd0);
`ifdef MAC_OPERAND_PACKER_STATS_EN
        checkOutput({name, ".stat_vectors"}, statVectors, 32'd0);
        checkOutput({name, ".stat_padded"}, statPadded, 32'd0);
`endif
    endtask

    initial begin
        bit took;
        int accepted;
        int readyLow;
        int firstClose;

        arstIn     = 1'b1;
        inValid    = 1'b0;
        inLast     = 1'b0;
        issueStall = 1'b0;
        for (int j = 0; j < EPB; j++) begin
            inA[j] = '0;
            inB[j] = '0;
        end

        @(posedge clk);
        #1;
        checkResetOutputs("reset");
        @(posedge clk);
        #1;
        arstIn = 1'b0;
        idle(1);

        $display("[TB] full vector");
        pulseQ.delete();
        for (int k = 0; k < BEATS; k++) applyStimulus(1 + k*EPB, 2, 1'b0, took);
        idle(4);
        checkOutput("full.pulses", 32'(pulseQ.size()), 32'd1);
        if (pulseQ.size() > 0) checkOutput("full.latency", pulseQ[0].cyc, 32'(lastAcceptCyc + 2));
        for (int i = 0; i < SIMD; i++) begin
            expA[i] = AW'(i + 1);
            expB[i] = BW'(2);
        end
        checkVector("full", 0, 1'b0);

        $display("[TB] negative lanes");
        pulseQ.delete();
        for (int k = 0; k < BEATS; k++) applyStimulus(32'h8000 + k*EPB, -5, 1'b0, took);
        idle(4);
        checkOutput("neg.pulses", 32'(pulseQ.size()), 32'd1);
        for (int i = 0; i < SIMD; i++) begin
            expA[i] = AW'(32'h8000 + i);
            expB[i] = 16'hFFFB;
        end
        checkVector("neg", 0, 1'b0);

        $display("[TB] early last");
        pulseQ.delete();
        for (int k = 0; k < 3; k++) applyStimulus(100 + k*EPB, 3, (k == 2), took);
        idle(4);
        checkOutput("early.pulses", 32'(pulseQ.size()), 32'd1);
        if (pulseQ.size() > 0) checkOutput("early.latency", pulseQ[0].cyc, 32'(lastAcceptCyc + 2));
        for (int i = 0; i < SIMD; i++) begin
            expA[i] = (i < 12) ? AW'(100 + i) : '0;
            expB[i] = (i < 12) ? BW'(3) : '0;
        end
        checkVector("early", 0, 1'b1);

        $display("[TB] backpressure");
        pulseQ.delete();
        issueStall = 1'b1;
        accepted   = 0;
        for (int n = 0; n < 20; n++) begin
            applyStimulus(300 + (accepted / BEATS) * 100 + (accepted % BEATS) * EPB,
                          (accepted / BEATS == 0) ? 1 : -1, 1'b0, took);
            if (took) accepted++;
        end
        checkOutput("bp.accepted", 32'(accepted), 32'd18);
        checkOutput("bp.in_ready_low", 32'(inReady), 32'd0);
        checkOutput("bp.no_pulse", 32'(pulseQ.size()), 32'd0);
        issueStall = 1'b0;
        idle(4);
        checkOutput("bp.pulses", 32'(pulseQ.size()), 32'd2);
        if (pulseQ.size() > 1) checkOutput("bp.back_to_back", pulseQ[1].cyc, pulseQ[0].cyc + 32'd1);
        checkOutput("bp.in_ready_high", 32'(inReady), 32'd1);
        for (int i = 0; i < SIMD; i++) begin
            expA[i] = AW'(300 + i);
            expB[i] = BW'(1);
        end
        checkVector("bp.first", 0, 1'b0);
        for (int i = 0; i < SIMD; i++) begin
            expA[i] = AW'(400 + i);
            expB[i] = 16'hFFFF;
        end
        checkVector("bp.second", 1, 1'b0);

        $display("[TB] streaming");
        pulseQ.delete();
        readyLow   = 0;
        firstClose = 0;
        for (int n = 0; n < 10 * BEATS; n++) begin
            applyStimulus(1000 + (n / BEATS) * SIMD + (n % BEATS) * EPB, n / BEATS, 1'b0, took);
            if (!took) readyLow++;
            if (n == BEATS - 1) firstClose = lastAcceptCyc;
        end
        idle(4);
        checkOutput("stream.ready_low", 32'(readyLow), 32'd0);
        checkOutput("stream.pulses", 32'(pulseQ.size()), 32'd10);
        if (pulseQ.size() > 0) checkOutput("stream.latency", pulseQ[0].cyc, 32'(firstClose + 2));
        for (int v = 1; v < 10 && v < pulseQ.size(); v++) begin
            checkOutput($sformatf("stream.spacing%0d", v), pulseQ[v].cyc - pulseQ[v-1].cyc, 32'd9);
        end
        for (int v = 0; v < 10; v++) begin
            for (int i = 0; i < SIMD; i++) begin
                expA[i] = AW'(1000 + v * SIMD + i);
                expB[i] = BW'(v);
            end
            checkVector($sformatf("stream.v%0d", v), v, 1'b0);
        end

        $display("[TB] reset mid-fill");
        pulseQ.delete();
        for (int k = 0; k < 5; k++) applyStimulus(32'h5000 + k*EPB, 32'h77, 1'b0, took);
        arstIn = 1'b1;
        #1;
        checkResetOutputs("midreset");
        @(posedge clk);
        #1;
        arstIn = 1'b0;
        idle(1);
        for (int k = 0; k < BEATS; k++) applyStimulus(700 + k*EPB, 11, 1'b0, took);
        idle(4);
        checkOutput("midreset.pulses", 32'(pulseQ.size()), 32'd1);
        for (int i = 0; i < SIMD; i++) begin
            expA[i] = AW'(700 + i);
            expB[i] = BW'(11);
        end
        checkVector("midreset", 0, 1'b0);

`ifdef MAC_OPERAND_PACKER_STATS_EN
        $display("[TB] stats");
        for (int k = 0; k < BEATS; k++) applyStimulus(1 + k*EPB, 2, 1'b0, took);
        for (int k = 0; k < 2; k++) applyStimulus(50 + k*EPB, 4, (k == 1), took);
        idle(4);
        checkOutput("stats.vectors", statVectors, 32'd3);
        checkOutput("stats.padded", statPadded, 32'd1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL timeout: simulation did not complete, got running expected finished");
        $fatal(1, "[TB] timeout");
    end

endmodule
